weight_pulse_gen: RTL
=====================

Name: weight_pulse_gen

Overview:
Upstream stimulus stage for the weight-write spike counter. Takes an 8-bit target weight through a valid/ready handshake and emits a single-bit programming pulse stream plus an enable. Each weight unit is exactly UNIT_LEN consecutive high cycles, so the downstream consecutive-ones counter advances its weight count once per unit. The stream ends with one low cycle that clears the downstream run counter, and the block then signals completion.

Parameters:
UNIT_LEN, 128, high cycles per weight unit; power of two, 2..128; must match the downstream run-length terminal count.
WW, 8, weight width for wt_data and unit_cnt.

Ports:
sys_clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
sys_en  input  1  global enable; low freezes all state.
wt_valid  input  1  target weight valid.
wt_data  input  WW  target weight in units.
wt_ready  output  1  block can accept a weight.
abort  input  1  terminate the current stream early.
pulse_out  output  1  programming bit stream; feeds downstream data_in.
pulse_en  output  1  stream enable; feeds downstream sys_en.
unit_cnt  output  WW  completed units in the current/last job.
busy  output  1  job in progress.
done  output  1  one-cycle completion strobe.

Behaviour:
- Reset values: state IDLE, pulse_out=0, pulse_en=0, unit_cnt=0, busy=0, done=0, wt_ready=0 for one cycle after reset release, then 1. Phase counter and target register cleared.
- States: IDLE, PULSE, GAP, DONE.
- All outputs are registered. pulse_en is combinational: sys_en AND (state is PULSE or GAP).
- sys_en=0: state, phase, unit_cnt, target and pulse_out hold; pulse_en=0; done is not issued. The DONE strobe stays pending until sys_en returns to 1.
- IDLE:
  - wt_ready=1.
  - Accept on wt_valid&wt_ready&sys_en. Accept loads target, clears unit_cnt and phase, and sets busy.
  - wt_data=0 goes directly to DONE, producing no pulses. Otherwise go to PULSE; pulse_out=1 from the next cycle.
- PULSE:
  - pulse_out=1. Phase increments each enabled cycle, modulo UNIT_LEN.
  - At phase=UNIT_LEN-1: unit_cnt increments and phase wraps to 0. If the new unit_cnt equals target, go to GAP.
  - Timing for weight W accepted at edge k: pulse_out high for enabled cycles k+1..k+W*UNIT_LEN.
- GAP:
  - Exactly one enabled cycle with pulse_out=0 and pulse_en=1, which clears the downstream run counter. Then go to DONE.
- DONE:
  - done=1 for one enabled cycle, busy deasserts with it, then go to IDLE. wt_ready rises the cycle after done.
  - Unit_cnt holds its final value until the next accept.
- abort (sampled only while sys_en=1 in PULSE or GAP):
  - In PULSE: next state GAP, pulse_out=0 from the next cycle.
  - If abort coincides with phase=UNIT_LEN-1, that unit is still counted, because the downstream counter has registered it.
  - Abort in GAP has no effect. Abort in IDLE or DONE is ignored.
- wt_valid while busy: ignored, since wt_ready=0. A new weight is never latched mid-job.
- unit_cnt never exceeds target. Target 2^WW-1 gives a maximum stream of (2^WW-1)*UNIT_LEN cycles with no overflow.
- Reset mid-job: immediate return to reset values. pulse_out drops asynchronously.

Decomposition:
- Shared package weight_wr_pkg:
  - state encoding (IDLE, PULSE, GAP, DONE);
  - WT_UNIT_LEN=128 and WT_W=8 constants, shared with the downstream counter so terminal counts cannot diverge.
- Sub-module weight_unit_timer:
  - log2(UNIT_LEN)-bit phase counter with enable, clear and terminal-count output;
  - instanced once; the FSM consumes its terminal-count output.

Test Plan:
- UNIT_LEN=128, accept W=3 at cycle 0 -> pulse_out high cycles 1..384, low at 385, done at 386, unit_cnt=3; a chained downstream counter reads 3.
- Accept W=0 -> no pulse_out; done one cycle after accept; unit_cnt=0; wt_ready back 2 cycles after accept.
- W=2, sys_en low for 10 cycles at phase 40 of unit 1 -> pulse_en low during the gap, pulse_out held high, total high cycles still 256, done delayed by 10; downstream reads 2.
- W=5, abort at phase 50 of unit 2 -> unit_cnt=1, pulse_out low next cycle, done 2 cycles after abort. Repeat with abort at phase 127 of unit 2 -> unit_cnt=2.
- UNIT_LEN=4, W=255 -> 1020 high cycles, unit_cnt=255, no wrap. wt_valid pulsed mid-job with W=7 -> ignored.
- rst_n asserted mid-PULSE of W=4 -> all outputs 0 immediately. After release, W=1 runs cleanly: 128 high cycles, unit_cnt=1.

Source files
------------

// File: rtl/weight_wr_pkg.sv
// Shared definitions for the weight-write path: job state encoding and the unit
// length / weight width that the downstream run-length counter must agree with.
package weight_wr_pkg;

  localparam int unsigned WT_UNIT_LEN = 128;
  localparam int unsigned WT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // The downstream counter is only enabled while the stream is on the wire
  function automatic logic stream_active(input wr_state_e s);
    return (s == ST_PULSE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/weight_unit_timer.sv
// Phase counter for one weight unit; tc_o marks the enabled cycle that completes a unit.
module weight_unit_timer
  import weight_wr_pkg::*;
#(
  parameter int unsigned UNIT_LEN = WT_UNIT_LEN
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned   PW         = $clog2(UNIT_LEN);
  localparam logic [PW-1:0] PHASE_LAST = PW'(UNIT_LEN - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // Next phase: clear has priority; UNIT_LEN is a power of two so the add wraps naturally
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = phase_q + PW'(1);
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tc_o = en_i && (phase_q == PHASE_LAST);

endmodule

// File: rtl/weight_pulse_gen.sv
// Weight programming stimulus: turns a target weight into W runs of UNIT_LEN ones,
// one clearing low cycle, then a done strobe.
module weight_pulse_gen
  import weight_wr_pkg::*;
#(
  parameter int unsigned UNIT_LEN = WT_UNIT_LEN,
  parameter int unsigned WW       = WT_W
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          sys_en,
  input  logic          wt_valid,
  input  logic [WW-1:0] wt_data,
  output logic          wt_ready,
  input  logic          abort,
  output logic          pulse_out,
  output logic          pulse_en,
  output logic [WW-1:0] unit_cnt,
  output logic          busy,
  output logic          done
);

  wr_state_e     state_q, state_d;
  logic [WW-1:0] target_q, target_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] cnt_inc;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          timer_en;
  logic          timer_clr;
  logic          unit_tc;

  assign timer_en = sys_en && (state_q == ST_PULSE);
  assign cnt_inc  = cnt_q + WW'(1);

  weight_unit_timer #(
    .UNIT_LEN(UNIT_LEN)
  ) u_timer (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .en_i   (timer_en),
    .clr_i  (timer_clr),
    .tc_o   (unit_tc)
  );

  // Job sequencing; nothing advances while sys_en is low, and a pending done re-issues
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timer_clr = 1'b0;
    if (sys_en) begin
      case (state_q)
        ST_IDLE: begin
          if (wt_valid && ready_q) begin
            target_d  = wt_data;
            cnt_d     = '0;
            timer_clr = 1'b1;
            busy_d    = 1'b1;
            if (wt_data == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_PULSE;
              pulse_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PULSE: begin
          // A unit finishing on the abort cycle was already seen downstream, so it counts
          if (unit_tc) begin
            cnt_d = cnt_inc;
          end else begin
            cnt_d = cnt_q;
          end
          if (abort || (unit_tc && (cnt_inc == target_q))) begin
            state_d = ST_GAP;
            pulse_d = 1'b0;
          end else begin
            state_d = ST_PULSE;
          end
        end
        ST_GAP: begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
        ST_DONE: begin
          if (done_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign pulse_out = pulse_q;
  assign pulse_en  = sys_en && stream_active(state_q);
  assign unit_cnt  = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wt_ready  = ready_q;

endmodule
